// File: rtl/multi_clk_div.sv
// multi_clk_div: multi-channel runtime-programmable clock/tick divider.
// Optional RESYNC realignment input when CLKDIV_RESYNC_EN is defined.
module multi_clk_div #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 8000,
    parameter int SEL_W   = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
`ifdef CLKDIV_RESYNC_EN
    input  logic              RESYNC,
`endif
    input  logic              DIV_WE,
    input  logic [SEL_W-1:0]  DIV_SEL,
    input  logic [CNT_W-1:0]  DIV_DATA,
    output logic              DIV_ACK,
    output logic              DIV_ERR,
    output logic [NUM_CH-1:0] CLK_OUT,
    output logic [NUM_CH-1:0] TICK
);

    localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0]  cnt      [NUM_CH];
    logic [CNT_W-1:0]  div_act  [NUM_CH];
    logic [CNT_W-1:0]  div_pend [NUM_CH];
    logic [CNT_W-1:0]  hi       [NUM_CH];
    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] commit;
    logic              accept;
    logic              resync;

`ifdef CLKDIV_RESYNC_EN
    assign resync = RESYNC & EN;
`else
    assign resync = 1'b0;
`endif

    // Write qualification, per-channel decode and period-boundary detect.
    always_comb begin
        accept = DIV_WE
              && ({{(32-SEL_W){1'b0}}, DIV_SEL} < 32'(NUM_CH))
              && (DIV_DATA >= TWO);
        wr_hit = '0;
        commit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hi[i]     = div_act[i] - (div_act[i] >> 1);
            wr_hit[i] = accept && (DIV_SEL == SEL_W'(i));
            commit[i] = !EN || resync || (cnt[i] == div_act[i] - ONE);
        end
    end

    // Counters, divisor commit/pending update and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            DIV_ACK <= 1'b0;
            DIV_ERR <= 1'b0;
            CLK_OUT <= '0;
            TICK    <= '0;
            pend_v  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                div_act[i]  <= DEF_VAL;
                div_pend[i] <= DEF_VAL;
            end
        end else begin
            DIV_ACK <= accept;
            DIV_ERR <= DIV_WE && !accept;
            for (int i = 0; i < NUM_CH; i++) begin
                TICK[i]    <= EN && (cnt[i] == '0);
                CLK_OUT[i] <= EN && (cnt[i] < hi[i]);
                if (commit[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + ONE;
                end
                // A same-cycle write lands after the commit, so it stays pending.
                if (commit[i] && pend_v[i]) begin
                    div_act[i] <= div_pend[i];
                    pend_v[i]  <= 1'b0;
                end
                if (wr_hit[i]) begin
                    div_pend[i] <= DIV_DATA;
                    pend_v[i]   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// tb_multi_clk_div: randomized + directed bench for multi_clk_div
// against a timestamp-based behavioural model.
module tb_multi_clk_div;

    localparam int NCH = 2;
    localparam int CW  = 16;
    localparam int DEF = 4;
    localparam int SW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          resync;
    logic          we;
    logic [SW-1:0] sel;
    logic [CW-1:0] data;
    logic          ack;
    logic          err;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int checks   = 0;
    int failures = 0;

    multi_clk_div #(
        .NUM_CH (NCH),
        .CNT_W  (CW),
        .DEF_DIV(DEF),
        .SEL_W  (SW)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .EN      (en),
`ifdef CLKDIV_RESYNC_EN
        .RESYNC  (resync),
`endif
        .DIV_WE  (we),
        .DIV_SEL (sel),
        .DIV_DATA(data),
        .DIV_ACK (ack),
        .DIV_ERR (err),
        .CLK_OUT (clk_out),
        .TICK    (tick)
    );

    always #5 clk = ~clk;

    // Model: each channel remembers the cycle its current period began;
    // phase is elapsed cycles since then.
    int         cyc = 0;
    int         start  [NCH];
    int         n_act  [NCH];
    int         n_pend [NCH];
    bit         pv     [NCH];
    logic       e_ack = 1'b0;
    logic       e_err = 1'b0;
    logic [NCH-1:0] e_clk  = '0;
    logic [NCH-1:0] e_tick = '0;

    always @(posedge clk) begin
        int  ph;
        bit  acc;
        bit  rsy;
        cyc++;
`ifdef CLKDIV_RESYNC_EN
        rsy = resync && en;
`else
        rsy = 1'b0;
`endif
        if (!rst_n) begin
            e_ack = 1'b0;
            e_err = 1'b0;
            e_clk = '0;
            e_tick = '0;
            for (int c = 0; c < NCH; c++) begin
                start[c] = cyc + 1;
                n_act[c] = DEF;
                pv[c] = 1'b0;
            end
        end else begin
            acc = we && (int'(sel) < NCH) && (int'(data) >= 2);
            e_ack = acc;
            e_err = we && !acc;
            for (int c = 0; c < NCH; c++) begin
                ph = cyc - start[c];
                e_tick[c] = en && (ph == 0);
                e_clk[c]  = en && (2 * ph < n_act[c]);
                if (!en || rsy || ph == n_act[c] - 1) begin
                    start[c] = cyc + 1;
                    if (pv[c]) begin
                        n_act[c] = n_pend[c];
                        pv[c] = 1'b0;
                    end
                end
                if (acc && int'(sel) == c) begin
                    n_pend[c] = int'(data);
                    pv[c] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        checks += 4;
        if (ack !== e_ack) begin
            failures++;
            $display("FAIL ack cyc=%0d actual=%b expected=%b", cyc, ack, e_ack);
        end
        if (err !== e_err) begin
            failures++;
            $display("FAIL err cyc=%0d actual=%b expected=%b", cyc, err, e_err);
        end
        if (clk_out !== e_clk) begin
            failures++;
            $display("FAIL clk_out cyc=%0d actual=%b expected=%b",
                     cyc, clk_out, e_clk);
        end
        if (tick !== e_tick) begin
            failures++;
            $display("FAIL tick cyc=%0d actual=%b expected=%b",
                     cyc, tick, e_tick);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_tick(input int ch, output int lead);
        lead = 0;
        do begin
            step();
            lead++;
        end while (!tick[ch] && lead < 200);
        if (!tick[ch]) lead = -1;
    endtask

    task automatic period_from_here(input int ch, output int per,
                                    output int hi);
        per = 0;
        hi = 0;
        do begin
            if (clk_out[ch]) hi++;
            per++;
            step();
        end while (!tick[ch] && per < 200);
        if (!tick[ch]) per = -1;
    endtask

    task automatic wr(input int s, input int d);
        we = 1'b1;
        sel = SW'(s);
        data = CW'(d);
    endtask

    logic [7:0] pat_c0, pat_c1, pat_t0;
    int lead, per, hi, k;

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        resync = 1'b0;
        we = 1'b0;
        sel = '0;
        data = '0;
        repeat (3) step();
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_tick", int'(tick), 0);
        rst_n = 1'b1;
        step();

        // Default divisor 4: 1,1,0,0 clock, tick every 4, first tick next cycle.
        en = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            step();
            pat_c0[i] = clk_out[0];
            pat_c1[i] = clk_out[1];
            pat_t0[i] = tick[0];
        end
        chk("default_clk0", int'(pat_c0), 8'b1100_1100);
        chk("default_clk1", int'(pat_c1), 8'b1100_1100);
        chk("default_tick0", int'(pat_t0), 8'b1000_1000);

        // Odd divisor on ch1; period in progress stays at 4.
        wait_tick(1, lead);
        wr(1, 5);
        step();
        chk("odd_ack", int'(ack), 1);
        we = 1'b0;
        wait_tick(1, lead);
        chk("odd_old_period", lead, 3);
        period_from_here(1, per, hi);
        chk("odd_period", per, 5);
        chk("odd_high", hi, 3);

        // Rejected writes.
        wr(0, 1);
        step();
        chk("rej_data_err", int'(err), 1);
        chk("rej_data_ack", int'(ack), 0);
        wr(3, 9);
        step();
        chk("rej_sel_err", int'(err), 1);
        we = 1'b0;
        wait_tick(0, lead);
        period_from_here(0, per, hi);
        chk("rej_period", per, 4);
        chk("rej_high", hi, 2);

        // Overwrite pending: 6 then 10, only 10 appears.
        wait_tick(0, lead);
        wr(0, 6);
        step();
        wr(0, 10);
        step();
        we = 1'b0;
        wait_tick(0, lead);
        chk("ovw_old_period", lead, 2);
        period_from_here(0, per, hi);
        chk("ovw_period", per, 10);
        chk("ovw_high", hi, 5);

        // EN drop with ch0 pending 7.
        wait_tick(0, lead);
        wr(0, 7);
        step();
        we = 1'b0;
        step();
        en = 1'b0;
        step();
        chk("en_off_clk", int'(clk_out), 0);
        chk("en_off_tick", int'(tick), 0);
        step();
        step();
        en = 1'b1;
        step();
        chk("en_on_tick", int'(tick), 3);
        chk("en_on_clk", int'(clk_out), 3);
        period_from_here(0, per, hi);
        chk("en_on_period", per, 7);
        chk("en_on_high", hi, 4);

`ifdef CLKDIV_RESYNC_EN
        // Resync two out-of-phase channels (4 and 6).
        wr(0, 4);
        step();
        wr(1, 6);
        step();
        we = 1'b0;
        repeat (30) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        step();
        chk("resync_tick", int'(tick), 3);
        k = 0;
        do begin
            step();
            k++;
        end while (tick != 2'b11 && k < 50);
        chk("resync_coincide", k, 12);
`endif

        // Randomized traffic checked by the model.
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 29) != 0);
            we = ($urandom_range(0, 5) == 0);
            sel = SW'($urandom_range(0, 3));
            data = CW'($urandom_range(0, 12));
`ifdef CLKDIV_RESYNC_EN
            resync = ($urandom_range(0, 19) == 0);
`endif
            step();
        end
        we = 1'b0;
        resync = 1'b0;
        en = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_clk_div.md
Name: multi_clk_div

Overview:
- Parametrised multi-channel clock/tick divider that replaces the fixed-ratio 12.5 kHz divider feeding the PmodAD1 sampling logic.
- Each channel produces a divided clock (≈50% duty) and a one-cycle tick strobe from the system clock.
- Divisors are runtime-programmable through a write port. A new divisor takes effect only at the channel's period boundary, so no output pulse is ever shortened.
- Sits between the board clock and the ADC/sensor-scan front ends.

Parameters:
- NUM_CH, 4: number of independent divider channels (1..16).
- CNT_W, 16: counter and divisor width in bits.
- DEF_DIV, 8000: reset divisor for every channel (100 MHz / 8000 = 12.5 kHz). Must satisfy 2 ≤ DEF_DIV < 2^CNT_W.
- SEL_W, 2: width of DIV_SEL. Must satisfy 2^SEL_W ≥ NUM_CH.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST_N  in  1  synchronous active-low reset.
- EN  in  1  global run enable.
- DIV_WE  in  1  divisor write strobe, single-cycle.
- DIV_SEL  in  SEL_W  target channel of the write.
- DIV_DATA  in  CNT_W  new divisor N (full period in CLK cycles).
- DIV_ACK  out  1  one-cycle pulse: write accepted.
- DIV_ERR  out  1  one-cycle pulse: write rejected.
- CLK_OUT  out  NUM_CH  divided clocks.
- TICK  out  NUM_CH  period-start strobes.

Behaviour:
- Per-channel state:
  - cnt[CNT_W]
  - div_act[CNT_W]
  - div_pend[CNT_W]
  - pend_v
- Reset (RST_N=0 at a clock edge): cnt=0, div_act=DEF_DIV, pend_v=0, CLK_OUT=0, TICK=0, DIV_ACK=0, DIV_ERR=0. Reset applied mid-period aborts the period immediately.
- Counting (EN=1):
  - If cnt == div_act-1: cnt<=0. If pend_v, then div_act<=div_pend and pend_v<=0.
  - Otherwise cnt<=cnt+1.
- Outputs are registered from the current cnt and div_act, so latency is 1 CLK:
  - TICK[i] <= EN & (cnt==0).
  - CLK_OUT[i] <= EN & (cnt < HI), where HI = div_act - (div_act>>1). High for ceil(N/2) cycles, low for floor(N/2).
  - Example N=5: high 3, low 2. Period is exactly N cycles.
- EN=0 (channels halted and phase-aligned):
  - All cnt<=0.
  - Any pending divisor commits immediately.
  - CLK_OUT and TICK go to 0 on the next cycle.
  - When EN rises, all channels restart in phase. The first TICK appears 1 cycle after the first EN=1 edge.
- Write port:
  - A write is accepted when DIV_WE=1, DIV_SEL < NUM_CH and DIV_DATA ≥ 2. On accept: div_pend[sel]<=DIV_DATA, pend_v<=1, DIV_ACK=1 on the next cycle.
  - Otherwise the write is rejected: DIV_ERR=1 on the next cycle and no state changes.
  - A second write to the same channel before commit overwrites div_pend. The last accepted value wins.
  - Write and commit in the same cycle: the commit uses the old div_pend, and the new value remains pending (pend_v stays 1).
- Wrap-around: cnt never exceeds div_act-1. Maximum divisor is 2^CNT_W-1.

Optional Feature:
- Macro: CLKDIV_RESYNC_EN.
- Defined: adds input port RESYNC (1 bit). A one-cycle pulse with EN=1 forces every channel to cnt<=0 and commits all pending divisors. The next-cycle outputs are computed from cnt=0, so TICK=1 on all channels together.
  - RESYNC has priority over normal counting and over period-boundary commits in the same cycle.
  - RESYNC is ignored while EN=0.
- Undefined: no RESYNC port. Channels only realign through EN=0 or reset.

Test Plan:
- Reset/default, DEF_DIV=4, NUM_CH=2, EN=1 after reset: CLK_OUT[0] follows the pattern 1,1,0,0 repeating. TICK[0] pulses every 4 cycles, the first one 1 cycle after EN rises. Both channels are identical.
- Odd divisor: write N=5 to ch1 → DIV_ACK next cycle. From the next period boundary, CLK_OUT[1] is high 3 / low 2, TICK period is 5. The period in progress at the write keeps N=4.
- Rejected writes: DIV_DATA=1 → DIV_ERR=1, no change. DIV_SEL=3 with NUM_CH=2 → DIV_ERR=1. Periods stay at 4.
- Overwrite pending: write 6 then 10 to ch0 in consecutive cycles mid-period → the next period is 10. The value 6 never appears.
- EN drop: EN=0 for 3 cycles mid-period with ch0 pending 7 → outputs 0 one cycle after EN falls. On EN=1, both channels restart aligned and ch0 period is 7 immediately.
- With CLKDIV_RESYNC_EN, ch0 N=4 and ch1 N=6 out of phase: RESYNC pulse → TICK[0] and TICK[1] are both 1 in the cycle after the pulse. The next coincident TICK is 12 cycles later.
